// File: rtl/park_gate_arbiter.sv
// Shared entrance/exit barrier arbiter for a car park with occupancy tracking.
// Latency: a request eligible at edge n is granted in cycle n+1; the barrier is raised from n+2.
// Backpressure: requests are level-held until granted; ineligible or mid-sequence requests are simply not served.
module park_gate_arbiter #(
    parameter int CAPACITY       = 8,
    parameter int CLOSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass_done,
    output logic       entry_gnt,
    output logic       exit_gnt,
    output logic       gate_open,
    output logic [3:0] occupancy,
    output logic       lot_full,
    output logic       fault
);

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1, close counter CLOSE_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    state_t        state;
    logic          lane_exit;   // lane latched for the sequence in flight
    logic          last_exit;   // lane served most recently, for round-robin
    logic [TW-1:0] open_cnt;
    logic [CW-1:0] close_cnt;
    logic [3:0]    occ;
    logic          fault_r;

    logic entry_ok;
    logic exit_ok;
    logic pick_exit;

    // Lane eligibility and round-robin pick; only consumed while in IDLE.
    always_comb begin
        entry_ok  = entry_req && !lot_full;
        exit_ok   = exit_req && (occ != 4'd0);
        pick_exit = exit_ok && (!entry_ok || !last_exit);
    end

    // Gate sequencing FSM together with the occupancy and fault bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lane_exit <= 1'b0;
            last_exit <= 1'b1;
            open_cnt  <= '0;
            close_cnt <= '0;
            occ       <= 4'd0;
            fault_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (entry_ok || exit_ok) begin
                        state     <= GRANT;
                        lane_exit <= pick_exit;
                        last_exit <= pick_exit;
                    end
                end
                GRANT: begin
                    state    <= OPEN;
                    open_cnt <= '0;
                end
                OPEN: begin
                    // A completed pass takes priority over a coincident timeout.
                    if (pass_done) begin
                        state     <= CLOSE;
                        close_cnt <= '0;
                        occ       <= lane_exit ? occ - 4'd1 : occ + 4'd1;
                    end else if (open_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= CLOSE;
                        close_cnt <= '0;
                        fault_r   <= 1'b1;
                    end else begin
                        open_cnt <= open_cnt + 1'b1;
                    end
                end
                CLOSE: begin
                    if (close_cnt == CW'(CLOSE_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        close_cnt <= close_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come only from registered state, never straight from inputs.
    always_comb begin
        entry_gnt = (state == GRANT) && !lane_exit;
        exit_gnt  = (state == GRANT) && lane_exit;
        gate_open = (state == OPEN);
        occupancy = occ;
        lot_full  = (occ == 4'(CAPACITY));
        fault     = fault_r;
    end

endmodule
